// File: rtl/im_loader.sv
// Instruction-memory loader: receives a length byte followed by little-endian
// 32-bit words over a byte stream and writes them into instruction memory.
module im_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        len_q, len_nx;
  logic [1:0]        idx_q, idx_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       wdata_nx;
  logic [ADDR_W:0]   cnt_nx;
  logic              accept;

  assign byte_ready = (state == S_LEN) || (state == S_DATA);
  assign accept     = byte_valid && byte_ready;
  assign im_we      = (state == S_WRITE);
  assign busy       = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
  assign cpu_hold   = busy || (state == S_ERR);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      im_addr  <= '0;
      im_wdata <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nx;
      len_q    <= len_nx;
      idx_q    <= idx_nx;
      im_addr  <= addr_nx;
      im_wdata <= wdata_nx;
      word_cnt <= cnt_nx;
    end
  end

  // Abort outranks a byte accepted in the same cycle, so a partial word is dropped.
  always_comb begin
    state_nx = state;
    len_nx   = len_q;
    idx_nx   = idx_q;
    addr_nx  = im_addr;
    wdata_nx = im_wdata;
    cnt_nx   = word_cnt;
    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_nx = S_LEN;
          addr_nx  = '0;
          cnt_nx   = '0;
        end
      end
      S_LEN: begin
        if (abort) begin
          state_nx = S_ERR;
        end else if (accept) begin
          len_nx = byte_data;
          idx_nx = '0;
          if (byte_data == 8'd0) begin
            state_nx = S_DONE;
          end else if (int'(byte_data) > MAX_WORDS) begin
            state_nx = S_ERR;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (abort) begin
          state_nx = S_ERR;
        end else if (accept) begin
          wdata_nx[{idx_q, 3'b000} +: 8] = byte_data;
          idx_nx = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_nx = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The strobe is already out this cycle, so the word counts even if aborted.
        cnt_nx = word_cnt + 1'b1;
        if (im_addr != {ADDR_W{1'b1}}) begin
          addr_nx = im_addr + 1'b1;
        end
        if (abort) begin
          state_nx = S_ERR;
        end else if (int'(word_cnt) + 1 == int'(len_q)) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_DATA;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a directed vector table, hand-written
// corner-case sequences and randomized sessions against a session-level model.
module tb_im_loader;

  localparam int ADDR_W = 6;
  localparam int MAX_WORDS = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [ADDR_W+31:0] wr_log[$];

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic              st;
    logic              bv;
    logic [7:0]        bd;
    logic [5:0]        fl;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   wc;
    logic              chk;
    logic [31:0]       wd;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic st, logic bv, logic [7:0] bd, logic [5:0] fl,
                              int addr, int wc, logic chk, logic [31:0] wd);
    vec_t v;
    v.st = st; v.bv = bv; v.bd = bd; v.fl = fl;
    v.addr = ADDR_W'(addr); v.wc = (ADDR_W+1)'(wc); v.chk = chk; v.wd = wd;
    return v;
  endfunction

  // {byte_ready, im_we, cpu_hold, busy, done, err}
  function automatic logic [5:0] flags();
    return {byte_ready, im_we, cpu_hold, busy, done, err};
  endfunction

  // Drives one cycle of inputs on the falling edge and records this cycle's writes/done.
  task automatic applyStimulus(input logic r, input logic s, input logic a,
                               input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; start = s; abort = a; byte_valid = v; byte_data = d;
    #1;
    if (im_we === 1'b1) wr_log.push_back({im_addr, im_wdata});
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, b);
      acc = byte_ready;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_log();
    wr_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [31:0] words[$];
    int n;
    int r;
    logic ok;

    $display("[TB] im_loader bench starting");

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("reset_flags", flags(), 6'b000000);
    checkOutput("reset_addr", im_addr, 0);
    checkOutput("reset_wdata", im_wdata, 0);
    checkOutput("reset_word_cnt", word_cnt, 0);

    // Two-word program loaded back to back; each row shows the outputs of that cycle
    vecs[0]  = mk(1, 0, 8'h00, 6'b000000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 8'h02, 6'b101100, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 8'h13, 6'b101100, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 8'h00, 6'b101100, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 8'h00, 6'b101100, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 8'h00, 6'b101100, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 8'h00, 6'b011100, 0, 0, 1, 32'h00000013);
    vecs[7]  = mk(0, 1, 8'h93, 6'b101100, 1, 1, 0, 0);
    vecs[8]  = mk(0, 1, 8'h00, 6'b101100, 1, 1, 0, 0);
    vecs[9]  = mk(0, 1, 8'h10, 6'b101100, 1, 1, 0, 0);
    vecs[10] = mk(0, 1, 8'h00, 6'b101100, 1, 1, 0, 0);
    vecs[11] = mk(0, 0, 8'h00, 6'b011100, 1, 1, 1, 32'h00100093);
    vecs[12] = mk(0, 0, 8'h00, 6'b000010, 2, 2, 0, 0);
    vecs[13] = mk(0, 0, 8'h00, 6'b000000, 2, 2, 0, 0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, vecs[i].st, 1'b0, vecs[i].bv, vecs[i].bd);
      checkOutput($sformatf("vec%0d_flags", i), flags(), vecs[i].fl);
      checkOutput($sformatf("vec%0d_addr", i), im_addr, vecs[i].addr);
      checkOutput($sformatf("vec%0d_word_cnt", i), word_cnt, vecs[i].wc);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d_wdata", i), im_wdata, vecs[i].wd);
    end

    // Zero-length session
    clear_log();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_byte(8'h00);
    idle(1);
    checkOutput("zero_len_done", done, 1);
    checkOutput("zero_len_hold", cpu_hold, 0);
    idle(1);
    checkOutput("zero_len_done_pulse", done, 0);
    checkOutput("zero_len_no_write", wr_log.size(), 0);
    checkOutput("zero_len_word_cnt", word_cnt, 0);

    // Oversize length, then recovery by start from the error state
    clear_log();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_byte(8'h41);
    idle(1);
    checkOutput("oversize_flags", flags(), 6'b001001);
    idle(2);
    checkOutput("oversize_sticky", flags(), 6'b001001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    idle(1);
    checkOutput("recover_err_clear", err, 0);
    checkOutput("recover_in_len", byte_ready, 1);
    send_byte(8'h01);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    idle(3);
    checkOutput("recover_nwrites", wr_log.size(), 1);
    if (wr_log.size() == 1) checkOutput("recover_write", wr_log[0], {6'd0, 32'hDEADBEEF});
    checkOutput("recover_err", err, 0);

    // Abort mid-word
    clear_log();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    checkOutput("abort_flags", flags(), 6'b001001);
    idle(3);
    checkOutput("abort_no_write", wr_log.size(), 0);

    // Slow source: valid every other cycle
    clear_log();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_byte(8'h01);
    idle(1); send_byte(8'h93);
    idle(1); send_byte(8'h00);
    idle(1); send_byte(8'h10);
    idle(1); send_byte(8'h00);
    idle(1);
    checkOutput("gap_write_latency", im_we, 1);
    checkOutput("gap_wdata", im_wdata, 32'h00100093);
    checkOutput("gap_addr", im_addr, 0);

    // Reset in the middle of a word
    idle(3);
    clear_log();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'hDD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hDD);
    checkOutput("midrst_flags", flags(), 6'b000000);
    checkOutput("midrst_addr", im_addr, 0);
    checkOutput("midrst_wdata", im_wdata, 0);
    checkOutput("midrst_word_cnt", word_cnt, 0);
    idle(2);
    checkOutput("midrst_no_write", wr_log.size(), 0);

    // Randomized sessions: a session writes word i at address i, or errors if too long
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (k == 0) n = MAX_WORDS;
      else if (r == 0) n = $urandom_range(MAX_WORDS + 1, 255);
      else if (r == 1) n = 0;
      else n = $urandom_range(1, 6);
      ok = (n <= MAX_WORDS);
      words.delete();
      if (ok) for (int i = 0; i < n; i++) words.push_back($urandom);
      clear_log();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      send_byte(8'(n));
      for (int w = 0; w < words.size(); w++) begin
        for (int b = 0; b < 4; b++) begin
          idle($urandom_range(0, 2));
          send_byte(words[w][8*b +: 8]);
        end
      end
      idle(4);
      checkOutput($sformatf("rnd%0d_nwrites", k), wr_log.size(), words.size());
      for (int i = 0; i < words.size() && i < wr_log.size(); i++)
        checkOutput($sformatf("rnd%0d_write%0d", k, i), wr_log[i], {ADDR_W'(i), words[i]});
      checkOutput($sformatf("rnd%0d_done", k), done_cnt, ok ? 1 : 0);
      checkOutput($sformatf("rnd%0d_err", k), err, !ok);
      checkOutput($sformatf("rnd%0d_hold", k), cpu_hold, !ok);
      checkOutput($sformatf("rnd%0d_word_cnt", k), word_cnt, ok ? n : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
